irda_mir_tx_sequencer: RTL and testbench

IRDA_MIR_TX_SEQUENCER -- requirements
Module: irda_mir_tx_sequencer

---
 rtl/irda_mir_tx_sequencer_pkg.sv | 19 +
 rtl/irda_mir_tx_sequencer_crc16.sv | 30 +++
 rtl/irda_mir_tx_sequencer.sv | 146 ++++++++++++++
 tb/tb_irda_mir_tx_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irda_mir_tx_sequencer_pkg.sv
// Shared state encoding and constants for the IrDA MIR transmit sequencer.
package irda_mir_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SFLAG,
    DATA,
    FCS,
    EFLAG,
    ABORT
  } state_t;

  localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  // Reflected form of x^16 + x^12 + x^5 + 1, suited to an LSB-first shift register.
  localparam logic [15:0] CRC_POLY   = 16'h8408;
  localparam int          ABORT_ONES = 7;

endpackage

// File: rtl/irda_mir_tx_sequencer_crc16.sv
// Bit-serial reflected CRC-CCITT for the MIR frame check sequence.
// Only present when IRDA_MIR_TX_FCS_EN is defined.
`ifdef IRDA_MIR_TX_FCS_EN
module irda_mir_crc16
  import irda_mir_tx_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= (r_crc >> 1) ^ (w_fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule
`endif

// File: rtl/irda_mir_tx_sequencer.sv
// IrDA MIR transmit sequencer: flags, LSB-first payload through an external bit stuffer, FCS, abort.
// Define IRDA_MIR_TX_FCS_EN to build the FCS state and CRC; otherwise DATA goes straight to EFLAG.
module irda_mir_tx_sequencer
  import irda_mir_tx_sequencer_pkg::*;
#(
  parameter int START_FLAGS = 2,
  parameter int STOP_FLAGS  = 1
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       mir_txbit_enable,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       bs_restart,
  output logic       stuffer_i_o,
  input  logic       shift_req_i,
  input  logic       stuffed_i,
  output logic       mir_tx_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam logic [7:0] START_LAST = 8'(START_FLAGS * 8 - 1);
  localparam logic [7:0] STOP_LAST  = 8'(STOP_FLAGS * 8 - 1);
  localparam logic [7:0] ABORT_LAST = 8'(ABORT_ONES - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, r_shift, r_next;
  logic       r_curLast, r_nextLast;
  logic [7:0] w_flag;
  logic       w_en, w_consume, w_fetchFirst, w_fetchNext, w_byteDone, w_fcsBit;

  assign w_flag       = FLAG_BYTE;
  assign w_en         = mir_txbit_enable;
  assign w_consume    = w_en && shift_req_i;
  assign w_fetchFirst = (r_state == SFLAG) && w_en && (r_cnt == START_LAST);
  // Next byte is prefetched while bit 6 goes out so bit 0 of it follows bit 7 without a gap.
  assign w_fetchNext  = (r_state == DATA) && w_consume && (r_cnt == 8'd6) && !r_curLast;
  assign w_byteDone   = (r_state == DATA) && w_consume && (r_cnt == 8'd7);

  assign tx_ready   = (w_fetchFirst || w_fetchNext) && !wb_rst_i;
  assign underrun_o = tx_ready && !tx_valid;
  assign busy_o     = (r_state != IDLE) && !wb_rst_i;

`ifdef IRDA_MIR_TX_FCS_EN
  logic [15:0] w_crc;

  irda_mir_crc16 u_crc (
    .i_clk  (clk),
    .i_rst  (wb_rst_i),
    .i_init ((r_state == IDLE) && w_en && tx_start),
    .i_en   ((r_state == DATA) && w_consume),
    .i_bit  (r_shift[0]),
    .o_crc  (w_crc)
  );

  assign w_fcsBit = ~w_crc[r_cnt[3:0]];
`else
  assign w_fcsBit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_en && tx_start) w_next = SFLAG;
      SFLAG: if (w_fetchFirst) w_next = tx_valid ? DATA : ABORT;
      DATA: begin
        if (w_fetchNext && !tx_valid) begin
          w_next = ABORT;
        end else if (w_byteDone && r_curLast) begin
`ifdef IRDA_MIR_TX_FCS_EN
          w_next = FCS;
`else
          w_next = EFLAG;
`endif
        end
      end
      FCS:   if (w_consume && (r_cnt == 8'd15)) w_next = EFLAG;
      EFLAG: if (w_en && (r_cnt == STOP_LAST)) w_next = IDLE;
      ABORT: if (w_en && (r_cnt == ABORT_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mir_tx_o    = 1'b1;
    bs_restart  = 1'b1;
    stuffer_i_o = 1'b0;
    case (r_state)
      SFLAG, EFLAG: mir_tx_o = w_flag[r_cnt[2:0]];
      DATA: begin
        bs_restart  = 1'b0;
        stuffer_i_o = r_shift[0];
        mir_tx_o    = stuffed_i;
      end
      FCS: begin
        bs_restart  = 1'b0;
        stuffer_i_o = w_fcsBit;
        mir_tx_o    = stuffed_i;
      end
      default: ;
    endcase
    if (wb_rst_i) begin
      mir_tx_o   = 1'b1;
      bs_restart = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_next     <= '0;
      r_curLast  <= 1'b0;
      r_nextLast <= 1'b0;
    end else begin
      r_state <= w_next;
      // In DATA/FCS the pointer only moves when the stuffer took the bit, never on an inserted zero.
      if ((w_next != r_state) || w_byteDone) begin
        r_cnt <= '0;
      end else if ((((r_state == SFLAG) || (r_state == EFLAG) || (r_state == ABORT)) && w_en) ||
                   (((r_state == DATA) || (r_state == FCS)) && w_consume)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_fetchFirst) begin
        r_shift   <= tx_data;
        r_curLast <= tx_last;
      end
      if (w_fetchNext) begin
        r_next     <= tx_data;
        r_nextLast <= tx_last;
      end
      if (w_byteDone) begin
        r_shift   <= r_next;
        r_curLast <= r_nextLast;
      end else if ((r_state == DATA) && w_consume) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_irda_mir_tx_sequencer.sv
// Bench for irda_mir_tx_sequencer: random bit-enable strobes, a bit-stuffer neighbour,
// and a frame-level line model built from flags, stuffed payload/FCS and abort rules.
module tb_irda_mir_tx_sequencer;

  localparam int START_FLAGS = 2;
  localparam int STOP_FLAGS  = 1;

  logic       clk;
  logic       wb_rst_i;
  logic       mir_txbit_enable;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       bs_restart;
  logic       stuffer_i_o;
  logic       shift_req_i;
  logic       stuffed_i;
  logic       mir_tx_o;
  logic       busy_o;
  logic       underrun_o;

  irda_mir_tx_sequencer #(
    .START_FLAGS (START_FLAGS),
    .STOP_FLAGS  (STOP_FLAGS)
  ) dut (
    .clk              (clk),
    .wb_rst_i         (wb_rst_i),
    .mir_txbit_enable (mir_txbit_enable),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_last          (tx_last),
    .tx_ready         (tx_ready),
    .bs_restart       (bs_restart),
    .stuffer_i_o      (stuffer_i_o),
    .shift_req_i      (shift_req_i),
    .stuffed_i        (stuffed_i),
    .mir_tx_o         (mir_tx_o),
    .busy_o           (busy_o),
    .underrun_o       (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neighbouring bit stuffer: after five consumed ones it emits a zero and withholds shift_req_i.
  int stCnt = 0;
  always @(posedge clk) begin
    if (bs_restart) stCnt <= 0;
    else if (mir_txbit_enable) begin
      if (stCnt == 5) stCnt <= 0;
      else if (stuffer_i_o) stCnt <= stCnt + 1;
      else stCnt <= 0;
    end
  end
  assign shift_req_i = (stCnt != 5);
  assign stuffed_i   = (stCnt == 5) ? 1'b0 : stuffer_i_o;

  logic [7:0] payload[$];
  bit         lineQ[$];
  bit         expQ[$];
  int         txIdx, validLimit, underrunCnt, acceptCnt;
  int         checks = 0;
  int         passes = 0;
  bit         lastBusy;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic driveTx();
    tx_valid = (txIdx < validLimit);
    tx_last  = (txIdx == payload.size() - 1);
    tx_data  = (txIdx < payload.size()) ? payload[txIdx] : 8'($urandom);
  endtask

  task automatic stepCycle();
    bit acc;
    @(negedge clk);
    if (mir_txbit_enable && busy_o) lineQ.push_back(mir_tx_o);
    if (underrun_o) underrunCnt++;
    acc      = tx_ready && tx_valid;
    lastBusy = busy_o;
    @(posedge clk);
    #1;
    if (acc) begin
      txIdx++;
      acceptCnt++;
    end
    if (lastBusy) tx_start = 1'b0;
    mir_txbit_enable = ($urandom_range(0, 3) != 0);
    driveTx();
  endtask

  function automatic logic [15:0] fcsOf();
    logic [15:0] crc;
    crc = 16'hFFFF;
    foreach (payload[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (crc[0] ^ payload[i][b]) crc = (crc >> 1) ^ 16'h8408;
        else crc = crc >> 1;
      end
    end
    return ~crc;
  endfunction

  // Expected line: opening flags, stuffed bits, then closing flags or seven abort ones.
  // An underrun at fetch k cuts the payload after bit 6 of byte k-1. No zero is stuffed
  // after the final data/FCS bit because the flags or abort ones follow directly.
  task automatic buildExpected();
    bit         raw[$];
    logic [7:0] flag;
    int         ones, nBits;
    bit         abortFrame;
`ifdef IRDA_MIR_TX_FCS_EN
    logic [15:0] fcs;
`endif
    flag = 8'h7E;
    expQ.delete();
    abortFrame = (validLimit < payload.size());
    nBits = abortFrame ? ((validLimit == 0) ? 0 : validLimit * 8 - 1) : payload.size() * 8;
    for (int i = 0; i < START_FLAGS * 8; i++) expQ.push_back(flag[i % 8]);
    for (int i = 0; i < nBits; i++) raw.push_back(payload[i / 8][i % 8]);
`ifdef IRDA_MIR_TX_FCS_EN
    fcs = fcsOf();
    if (!abortFrame) for (int b = 0; b < 16; b++) raw.push_back(fcs[b]);
`endif
    ones = 0;
    for (int i = 0; i < raw.size(); i++) begin
      expQ.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5 && i != raw.size() - 1) begin
        expQ.push_back(1'b0);
        ones = 0;
      end
    end
    if (abortFrame) repeat (7) expQ.push_back(1'b1);
    else for (int i = 0; i < STOP_FLAGS * 8; i++) expQ.push_back(flag[i % 8]);
  endtask

  task automatic applyStimulus(input string tag, input int limit);
    int cyc;
    int failsBefore;
    bit seen;
    bit abortFrame;
    validLimit  = limit;
    abortFrame  = (limit < payload.size());
    txIdx       = 0;
    acceptCnt   = 0;
    underrunCnt = 0;
    lastBusy    = 1'b0;
    lineQ.delete();
    buildExpected();
    driveTx();
    tx_start = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 5000 && !(seen && !lastBusy)) begin
      stepCycle();
      if (lastBusy) seen = 1'b1;
      cyc++;
    end
    checkOutput({tag, "_done"}, 32'(seen && !lastBusy), 32'd1);
    checkOutput({tag, "_len"}, lineQ.size(), expQ.size());
    failsBefore = checks - passes;
    for (int i = 0; i < lineQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), 32'(lineQ[i]), 32'(expQ[i]));
      if (checks - passes > failsBefore) break;
    end
    checkOutput({tag, "_underrun"}, underrunCnt, abortFrame ? 1 : 0);
    checkOutput({tag, "_accepted"}, acceptCnt, abortFrame ? limit : payload.size());
    checkOutput({tag, "_idle_line"}, 32'(mir_tx_o), 32'd1);
  endtask

  initial begin
    int len;
    int cyc;
    bit ds[$];
    int ones;
    logic [15:0] fcsSeen;

    wb_rst_i = 1'b1;
    tx_start = 1'b0;
    mir_txbit_enable = 1'b1;
    payload = {};
    validLimit = 0;
    txIdx = 0;
    driveTx();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_line", 32'(mir_tx_o), 32'd1);
    checkOutput("rst_bs_restart", 32'(bs_restart), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_o), 32'd0);
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("post_rst_line", 32'(mir_tx_o), 32'd1);

    payload = {8'h00};
    applyStimulus("zero_byte", 1);

    payload = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    applyStimulus("check_str", 9);
`ifdef IRDA_MIR_TX_FCS_EN
    ds.delete();
    ones = 0;
    for (int i = START_FLAGS * 8; i < lineQ.size() - STOP_FLAGS * 8; i++) begin
      if (ones == 5) begin
        ones = 0;
        continue;
      end
      ds.push_back(lineQ[i]);
      ones = lineQ[i] ? ones + 1 : 0;
    end
    fcsSeen = '0;
    if (ds.size() >= 16) for (int b = 0; b < 16; b++) fcsSeen[b] = ds[ds.size() - 16 + b];
    checkOutput("fcs_123456789", 32'(fcsSeen), 32'h906E);
`endif

    payload = {8'hFF, 8'hFF};
    applyStimulus("all_ones", 2);

    payload = {8'h12, 8'h34, 8'h56};
    applyStimulus("underrun_2nd", 1);

    payload = {8'hA5};
    applyStimulus("a5", 1);

    // Reset in the middle of the trailer, then a clean frame.
    payload = {8'h00};
    validLimit = 1;
    txIdx = 0;
    lineQ.delete();
    driveTx();
    tx_start = 1'b1;
    cyc = 0;
    while (lineQ.size() < START_FLAGS * 8 + 13 && cyc < 2000) begin
      stepCycle();
      cyc++;
    end
    checkOutput("midfcs_reached", 32'(lineQ.size() >= START_FLAGS * 8 + 13), 32'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_held_line", 32'(mir_tx_o), 32'd1);
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_line", 32'(mir_tx_o), 32'd1);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_bs_restart", 32'(bs_restart), 32'd1);
    checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd0);
    payload = {8'h5A, 8'hC3};
    applyStimulus("after_rst", 2);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 6);
      payload = {};
      for (int i = 0; i < len; i++)
        payload.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 3) == 0) applyStimulus($sformatf("rand%0d", f), $urandom_range(0, len - 1));
      else applyStimulus($sformatf("rand%0d", f), len);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
